if_id_skid_reg: RTL

- Parametrised IF/ID pipeline register with valid/ready handshake on both sides and a one-entry skid buffer.
- Carries pc_incr, instr and jumpoffset from fetch to decode.
- Adds back-pressure (stall), synchronous flush with bubble insertion, and a registered upstream ready, so ID stalls do not create a combinational path into IF.

---
 rtl/if_id_skid_if.sv | 29 ++
 rtl/if_id_skid_reg.sv | 123 ++++++++++++
 2 files changed

// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle: fetch-side valid/ready plus fields, decode-side valid/ready plus registered fields.
// slave is the pipeline register's view; master is the surrounding fetch/decode logic.
interface if_id_skid_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int OFF_W   = 26
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_incr;
  logic [INSTR_W-1:0] instr;
  logic [OFF_W-1:0]   jumpoffset;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pi1_incr;
  logic [INSTR_W-1:0] pi1_instr;
  logic [OFF_W-1:0]   pi1_jumpoffset;

  modport slave (
    input  in_valid, pc_incr, instr, jumpoffset, flush, out_ready,
    output in_ready, out_valid, pi1_incr, pi1_instr, pi1_jumpoffset
  );

  modport master (
    output in_valid, pc_incr, instr, jumpoffset, flush, out_ready,
    input  in_ready, out_valid, pi1_incr, pi1_instr, pi1_jumpoffset
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer; entry visible on pi1_* one cycle after accept.
// in_ready is a flop (low only when both main and skid are full), so decode stalls never reach fetch combinationally.
module if_id_skid_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 OFF_W     = 26,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input logic         clk,
  input logic         rst,
  if_id_skid_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef enum logic [1:0] {M_HOLD, M_IN, M_SKID, M_BUBBLE} main_sel_t;
  typedef enum logic [1:0] {S_HOLD, S_IN, S_CLEAR} skid_sel_t;

  state_t    state, state_nxt;
  main_sel_t main_sel;
  skid_sel_t skid_sel;

  logic               in_ready_q;
  logic               accept, deliver;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [OFF_W-1:0]   main_off, skid_off;

  assign accept  = bus.in_valid & in_ready_q;
  assign deliver = (state != EMPTY) & bus.out_ready;

  always_comb begin
    state_nxt = state;
    main_sel  = M_HOLD;
    skid_sel  = S_HOLD;
    if (bus.flush) begin
      state_nxt = EMPTY;
      main_sel  = M_BUBBLE;
      skid_sel  = S_CLEAR;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt = ONE;
          main_sel  = M_IN;
        end
        ONE: begin
          if (accept && deliver) begin
            main_sel = M_IN;
          end else if (accept) begin
            state_nxt = TWO;
            skid_sel  = S_IN;
          end else if (deliver) begin
            state_nxt = EMPTY;
            main_sel  = M_BUBBLE;
          end
        end
        TWO: if (deliver) begin
          state_nxt = ONE;
          main_sel  = M_SKID;
          skid_sel  = S_CLEAR;
        end
        default: begin
          state_nxt = EMPTY;
          main_sel  = M_BUBBLE;
          skid_sel  = S_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      main_off   <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_off   <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
      case (main_sel)
        M_IN: begin
          main_pc    <= bus.pc_incr;
          main_instr <= bus.instr;
          main_off   <= bus.jumpoffset;
        end
        M_SKID: begin
          main_pc    <= skid_pc;
          main_instr <= skid_instr;
          main_off   <= skid_off;
        end
        M_BUBBLE: begin
          main_pc    <= '0;
          main_instr <= NOP_INSTR;
          main_off   <= '0;
        end
        default: ;
      endcase
      case (skid_sel)
        S_IN: begin
          skid_pc    <= bus.pc_incr;
          skid_instr <= bus.instr;
          skid_off   <= bus.jumpoffset;
        end
        S_CLEAR: begin
          skid_pc    <= '0;
          skid_instr <= '0;
          skid_off   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = (state != EMPTY);
  assign bus.pi1_incr       = main_pc;
  assign bus.pi1_instr      = main_instr;
  assign bus.pi1_jumpoffset = main_off;

endmodule
